// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the rv32 core.
// Outputs are decoded combinationally from the state register, opcode and the ready inputs.
// They are forced to 0 while rst is high.
// Optional build macro ILLEGAL_TRAP_EN: when it is defined, DECODE halts on unknown opcodes
// and on SYSTEM with funct3 != 000, and sets illegal. When it is undefined, those
// instructions retire as NOPs and illegal stays 0.
module core_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       retire,
  output logic       halted,
  output logic       timeout,
  output logic       illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_set;
  logic               sel_a, sel_b;
  logic               is_sys_halt, is_ill, wd_expire;
`ifdef ILLEGAL_TRAP_EN
  logic               illegal_q, illegal_set;
`endif

  // Opcode classification and ALU operand selects shared by EXEC/MEM/WB
  always_comb begin
    sel_a  = 1'b0;
    sel_b  = 1'b0;
    is_ill = 1'b0;
    case (opcode)
      OPC_OP, OPC_BRANCH, OPC_LUI, OPC_FENCE: ;
      OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR: sel_b = 1'b1;
      OPC_AUIPC, OPC_JAL: begin
        sel_a = 1'b1;
        sel_b = 1'b1;
      end
      OPC_SYSTEM: is_ill = (funct3 != 3'b000);
      default: is_ill = 1'b1;
    endcase
    is_sys_halt = (opcode == OPC_SYSTEM) && (funct3 == 3'b000);
  end

  // Watchdog expiry: a wait of TIMEOUT_CYCLES cycles without ready (0 disables)
  always_comb begin
    wd_expire = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    timeout_set = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'b00;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    retire      = 1'b0;
    halted      = 1'b0;
    timeout     = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      timeout = timeout_q;
`ifdef ILLEGAL_TRAP_EN
      illegal = illegal_q;
`endif
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (wd_expire) begin
            timeout_set = 1'b1;
            state_d     = S_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (is_sys_halt) begin
            state_d = S_HALT;
          end
`ifdef ILLEGAL_TRAP_EN
          else if (is_ill) begin
            illegal_set = 1'b1;
            state_d     = S_HALT;
          end
`endif
          else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_src_a = sel_a;
          alu_src_b = sel_b;
          if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
            state_d = S_MEM;
          end else if (opcode == OPC_BRANCH) begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'b01 : 2'b00;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if ((opcode == OPC_FENCE) || is_ill) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          alu_src_a = sel_a;
          alu_src_b = sel_b;
          dmem_req  = 1'b1;
          dmem_we   = (opcode == OPC_STORE);
          if (dmem_ready) begin
            if (opcode == OPC_STORE) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wd_expire) begin
            timeout_set = 1'b1;
            state_d     = S_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          alu_src_a = sel_a;
          alu_src_b = sel_b;
          rf_we     = 1'b1;
          pc_we     = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
          case (opcode)
            OPC_LOAD:          wb_sel = 2'b01;
            OPC_JAL, OPC_JALR: wb_sel = 2'b10;
            OPC_LUI:           wb_sel = 2'b11;
            default:           wb_sel = 2'b00;
          endcase
          case (opcode)
            OPC_JAL:  pc_sel = 2'b01;
            OPC_JALR: pc_sel = 2'b10;
            default:  pc_sel = 2'b00;
          endcase
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = S_HALT;
        end
      endcase
    end
  end

  // State, watchdog counter and sticky halt-cause flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_q | timeout_set;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= illegal_q | illegal_set;
`endif
    end
  end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: directed per-cycle vectors for core_ctrl_fsm (TIMEOUT_CYCLES = 8).
module tb_core_ctrl_fsm;

  localparam int unsigned TO = 8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       imem_req, imem_ready, ir_we;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       alu_src_a, alu_src_b, rf_we, pc_we, retire, halted, timeout, illegal;
  logic [1:0] wb_sel, pc_sel;

  int n_checks = 0;
  int n_errors = 0;
  int nret;

  core_ctrl_fsm #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rf_we(rf_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire), .halted(halted),
    .timeout(timeout), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs: {imem_req, ir_we, dmem_req, dmem_we, a, b, rf_we, wb_sel,
  // pc_we, pc_sel, retire, halted, timeout, illegal}
  logic [16:0] ov;
  assign ov = {imem_req, ir_we, dmem_req, dmem_we, alu_src_a, alu_src_b, rf_we, wb_sel,
               pc_we, pc_sel, retire, halted, timeout, illegal};

  function automatic logic [16:0] e(input logic ireq, input logic iwe, input logic dreq,
                                    input logic dwe, input logic sa, input logic sb,
                                    input logic rfw, input logic [1:0] wsel, input logic pwe,
                                    input logic [1:0] psel, input logic ret, input logic hlt,
                                    input logic to, input logic ill);
    return {ireq, iwe, dreq, dwe, sa, sb, rfw, wsel, pwe, psel, ret, hlt, to, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance to just after the next edge
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    check(tag, 32'(ov), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [16:0] Z = 17'h0;

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc("reset_outputs", Z);
    rst = 1'b0;

    // OP with zero-wait memory
    opcode = OPC_OP; imem_ready = 1'b1; dmem_ready = 1'b1;
    cyc("op_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("op_decode", Z);
    cyc("op_exec",   Z);
    cyc("op_wb",     e(0,0,0,0,0,0,1,2'b00,1,2'b00,1,0,0,0));
    nret = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (retire) nret++;
      @(posedge clk); #1;
    end
    check("op_retire_rate", 32'(nret), 32'd2);

    // LOAD with dmem_ready delayed three cycles
    opcode = OPC_LOAD; dmem_ready = 1'b0;
    cyc("ld_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("ld_decode", Z);
    cyc("ld_exec",   e(0,0,0,0,0,1,0,2'b00,0,2'b00,0,0,0,0));
    for (int i = 0; i < 3; i++) cyc("ld_mem_wait", e(0,0,1,0,0,1,0,2'b00,0,2'b00,0,0,0,0));
    dmem_ready = 1'b1;
    cyc("ld_mem_done", e(0,0,1,0,0,1,0,2'b00,0,2'b00,0,0,0,0));
    cyc("ld_wb",       e(0,0,0,0,0,1,1,2'b01,1,2'b00,1,0,0,0));

    // STORE zero-wait
    opcode = OPC_STORE;
    cyc("st_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("st_decode", Z);
    cyc("st_exec",   e(0,0,0,0,0,1,0,2'b00,0,2'b00,0,0,0,0));
    cyc("st_mem",    e(0,0,1,1,0,1,0,2'b00,1,2'b00,1,0,0,0));

    // BRANCH taken then not taken
    opcode = OPC_BRANCH; branch_taken = 1'b1;
    cyc("bt_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("bt_decode", Z);
    cyc("bt_exec",   e(0,0,0,0,0,0,0,2'b00,1,2'b01,1,0,0,0));
    branch_taken = 1'b0;
    cyc("bn_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("bn_decode", Z);
    cyc("bn_exec",   e(0,0,0,0,0,0,0,2'b00,1,2'b00,1,0,0,0));

    // JALR, JAL, LUI, FENCE
    opcode = OPC_JALR;
    cyc("jalr_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("jalr_decode", Z);
    cyc("jalr_exec",   e(0,0,0,0,0,1,0,2'b00,0,2'b00,0,0,0,0));
    cyc("jalr_wb",     e(0,0,0,0,0,1,1,2'b10,1,2'b10,1,0,0,0));
    opcode = OPC_JAL;
    cyc("jal_fetch",   e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("jal_decode",  Z);
    cyc("jal_exec",    e(0,0,0,0,1,1,0,2'b00,0,2'b00,0,0,0,0));
    cyc("jal_wb",      e(0,0,0,0,1,1,1,2'b10,1,2'b01,1,0,0,0));
    opcode = OPC_LUI;
    cyc("lui_fetch",   e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("lui_decode",  Z);
    cyc("lui_exec",    Z);
    cyc("lui_wb",      e(0,0,0,0,0,0,1,2'b11,1,2'b00,1,0,0,0));
    opcode = OPC_FENCE;
    cyc("fence_fetch", e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("fence_decode", Z);
    cyc("fence_exec",  e(0,0,0,0,0,0,0,2'b00,1,2'b00,1,0,0,0));

    // Ready arriving in the watchdog expiry cycle wins
    opcode = OPC_OP; imem_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc("wd_wait", e(1,0,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    imem_ready = 1'b1;
    cyc("wd_ready_wins", e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("wd_decode",     Z);
    cyc("wd_exec",       Z);
    cyc("wd_wb",         e(0,0,0,0,0,0,1,2'b00,1,2'b00,1,0,0,0));

    // Reset asserted mid-MEM drops dmem_req immediately
    opcode = OPC_LOAD; dmem_ready = 1'b0;
    cyc("rm_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("rm_decode", Z);
    cyc("rm_exec",   e(0,0,0,0,0,1,0,2'b00,0,2'b00,0,0,0,0));
    cyc("rm_mem",    e(0,0,1,0,0,1,0,2'b00,0,2'b00,0,0,0,0));
    rst = 1'b1;
    cyc("rm_rst_same_cycle", Z);
    cyc("rm_rst_hold", Z);
    rst = 1'b0; imem_ready = 1'b0;
    cyc("rm_after_release", e(1,0,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    do_reset();

    // Opcode 0000000
    opcode = 7'b0000000; imem_ready = 1'b1;
    cyc("ill_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("ill_decode", Z);
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_halt0", e(0,0,0,0,0,0,0,2'b00,0,2'b00,0,1,0,1));
    cyc("ill_halt1", e(0,0,0,0,0,0,0,2'b00,0,2'b00,0,1,0,1));
    do_reset();
`else
    cyc("ill_nop_exec", e(0,0,0,0,0,0,0,2'b00,1,2'b00,1,0,0,0));
`endif

    // ECALL halts without a sticky cause; ready inputs ignored in HALT
    opcode = OPC_SYSTEM; funct3 = 3'b000;
    cyc("ecall_fetch",  e(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("ecall_decode", Z);
    cyc("ecall_halt0",  e(0,0,0,0,0,0,0,2'b00,0,2'b00,0,1,0,0));
    cyc("ecall_halt1",  e(0,0,0,0,0,0,0,2'b00,0,2'b00,0,1,0,0));
    do_reset();

    // Watchdog expiry on fetch: 9 request cycles, then HALT with timeout
    opcode = OPC_OP; imem_ready = 1'b0;
    for (int i = 0; i < 9; i++) cyc("to_wait", e(1,0,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));
    cyc("to_halt0", e(0,0,0,0,0,0,0,2'b00,0,2'b00,0,1,1,0));
    imem_ready = 1'b1;
    cyc("to_halt1", e(0,0,0,0,0,0,0,2'b00,0,2'b00,0,1,1,0));
    imem_ready = 1'b0; rst = 1'b1;
    cyc("to_rst", Z);
    rst = 1'b0;
    cyc("to_refetch", e(1,0,0,0,0,0,0,2'b00,0,2'b00,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
